// File: rtl/id_ex_interlock.sv
// id_ex_interlock
//
// ID->EX pipeline register for the in-order MIPS core. Latches the decoded
// control bundle and operands, keeps a three-entry shadow scoreboard of the
// destinations held by EX, MEM and WB, stalls ID on a load-use dependence
// until the load reaches WB, and emits registered forwarding selects for
// ALU producers still in EX or MEM.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   id_valid / id_ready    decoder handshake (id_ready is combinational)
//   id_rs/rt/rd            register fields
//   id_reg_a/b_valid       instruction reads rs / rt
//   id_mem_read            instruction is a load
//   id_reg_write(_tgt)     writes a register; one-hot target
//                          [0] rd [1] hi [2] lo [3] nop [4] rt [5] r31
//   id_aluop .. id_pc      remaining decoded bundle and operands
//   ex_ready               backend advances this cycle
//   ex_valid, ex_*         registered bundle, ex_dst = resolved GPR (0 = none)
//   ex_fwd_a/b             0 register file, 1 EX result, 2 MEM result
//   stall_cycles           number of interlock stall cycles (wraps)
module id_ex_interlock #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic          id_reg_a_valid,
  input  logic          id_reg_b_valid,
  input  logic          id_mem_read,
  input  logic          id_reg_write,
  input  logic [5:0]    id_reg_write_tgt,
  input  logic [15:0]   id_aluop,
  input  logic [3:0]    id_alu_b_src,
  input  logic [4:0]    id_mem_wen_pick,
  input  logic [15:0]   id_reg_write_src,
  input  logic [DW-1:0] id_a,
  input  logic [DW-1:0] id_b,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic          ex_reg_a_valid,
  output logic          ex_reg_b_valid,
  output logic          ex_mem_read,
  output logic          ex_reg_write,
  output logic [5:0]    ex_reg_write_tgt,
  output logic [15:0]   ex_aluop,
  output logic [3:0]    ex_alu_b_src,
  output logic [4:0]    ex_mem_wen_pick,
  output logic [15:0]   ex_reg_write_src,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc,
  output logic [4:0]    ex_dst,
  output logic [1:0]    ex_fwd_a,
  output logic [1:0]    ex_fwd_b,
  output logic [31:0]   stall_cycles
);

  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
    logic       ld;
  } slot_t;

  typedef struct packed {
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          a_v;
    logic          b_v;
    logic          mem_read;
    logic          reg_write;
    logic [5:0]    tgt;
    logic [15:0]   aluop;
    logic [3:0]    alu_b_src;
    logic [4:0]    mem_wen_pick;
    logic [15:0]   reg_write_src;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [4:0]    dst;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
  } bundle_t;

  // Returns {writes_gpr, dst}. Writes to $0 are discarded by the register
  // file, so they are treated as no write at all.
  function automatic logic [5:0] resolve_dst(input logic       wr,
                                             input logic [5:0] tgt,
                                             input logic [4:0] rd,
                                             input logic [4:0] rt);
    logic [4:0] d;
    d = 5'd0;
    if (tgt[0])      d = rd;
    else if (tgt[4]) d = rt;
    else if (tgt[5]) d = 5'd31;
    return (wr && d != 5'd0) ? {1'b1, d} : 6'd0;
  endfunction

  // Verdict of one slot for one source: {hit, hazard, sel}. A load only
  // stalls while it is still in flight (EX or MEM); in WB its value is
  // already visible through the write-through register file.
  function automatic logic [3:0] slot_verdict(input slot_t      s,
                                              input logic [4:0] src,
                                              input logic       in_flight,
                                              input logic [1:0] sel);
    logic hit;
    logic haz;
    hit = s.vld && (s.dst == src);
    haz = s.ld && in_flight;
    return {hit, haz, haz ? 2'd0 : sel};
  endfunction

  // Returns {hazard, sel}. Slots are applied oldest first so the youngest
  // matching producer decides, which lets an ALU result in EX mask an older
  // load of the same register in MEM.
  function automatic logic [2:0] src_lookup(input logic       rv,
                                            input logic [4:0] src,
                                            input slot_t      s_ex,
                                            input slot_t      s_mem,
                                            input slot_t      s_wb);
    logic [2:0] r;
    logic [3:0] v;
    r = 3'b000;
    if (rv && src != 5'd0) begin
      v = slot_verdict(s_wb, src, 1'b0, 2'd0);
      if (v[3]) r = v[2:0];
      v = slot_verdict(s_mem, src, 1'b1, 2'd2);
      if (v[3]) r = v[2:0];
      v = slot_verdict(s_ex, src, 1'b1, 2'd1);
      if (v[3]) r = v[2:0];
    end
    return r;
  endfunction

  slot_t      sb_ex_p1;
  slot_t      sb_mem_p2;
  slot_t      sb_wb_p3;
  bundle_t    id_bundle_p0;
  bundle_t    ex_bundle_p1;
  logic [2:0] look_a_p0;
  logic [2:0] look_b_p0;
  logic [5:0] dst_p0;
  logic       hazard_p0;
  logic       issue_p0;

  // ---- ID stage: dependence check against the pre-shift scoreboard ----
  assign dst_p0    = resolve_dst(id_reg_write, id_reg_write_tgt, id_rd, id_rt);
  assign look_a_p0 = src_lookup(id_reg_a_valid, id_rs, sb_ex_p1, sb_mem_p2, sb_wb_p3);
  assign look_b_p0 = src_lookup(id_reg_b_valid, id_rt, sb_ex_p1, sb_mem_p2, sb_wb_p3);
  assign hazard_p0 = look_a_p0[2] | look_b_p0[2];
  assign id_ready  = ex_ready & ~hazard_p0 & ~rst;
  assign issue_p0  = id_valid & id_ready;

  always_comb begin
    id_bundle_p0               = '0;
    id_bundle_p0.rs            = id_rs;
    id_bundle_p0.rt            = id_rt;
    id_bundle_p0.rd            = id_rd;
    id_bundle_p0.a_v           = id_reg_a_valid;
    id_bundle_p0.b_v           = id_reg_b_valid;
    id_bundle_p0.mem_read      = id_mem_read;
    id_bundle_p0.reg_write     = id_reg_write;
    id_bundle_p0.tgt           = id_reg_write_tgt;
    id_bundle_p0.aluop         = id_aluop;
    id_bundle_p0.alu_b_src     = id_alu_b_src;
    id_bundle_p0.mem_wen_pick  = id_mem_wen_pick;
    id_bundle_p0.reg_write_src = id_reg_write_src;
    id_bundle_p0.a             = id_a;
    id_bundle_p0.b             = id_b;
    id_bundle_p0.imm           = id_imm;
    id_bundle_p0.pc            = id_pc;
    id_bundle_p0.dst           = dst_p0[4:0];
    id_bundle_p0.fwd_a         = look_a_p0[1:0];
    id_bundle_p0.fwd_b         = look_b_p0[1:0];
  end

  // ---- ID -> EX register and EX/MEM/WB scoreboard shift ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_bundle_p1 <= '0;
      sb_ex_p1     <= '0;
      sb_mem_p2    <= '0;
      sb_wb_p3     <= '0;
      stall_cycles <= 32'd0;
    end else if (ex_ready) begin
      sb_wb_p3  <= sb_mem_p2;
      sb_mem_p2 <= sb_ex_p1;
      if (issue_p0) begin
        ex_valid     <= 1'b1;
        ex_bundle_p1 <= id_bundle_p0;
        sb_ex_p1     <= '{vld: dst_p0[5], dst: dst_p0[4:0], ld: id_mem_read};
      end else begin
        ex_valid     <= 1'b0;
        ex_bundle_p1 <= '0;
        sb_ex_p1     <= '0;
      end
      if (id_valid && hazard_p0) stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign ex_rs            = ex_bundle_p1.rs;
  assign ex_rt            = ex_bundle_p1.rt;
  assign ex_rd            = ex_bundle_p1.rd;
  assign ex_reg_a_valid   = ex_bundle_p1.a_v;
  assign ex_reg_b_valid   = ex_bundle_p1.b_v;
  assign ex_mem_read      = ex_bundle_p1.mem_read;
  assign ex_reg_write     = ex_bundle_p1.reg_write;
  assign ex_reg_write_tgt = ex_bundle_p1.tgt;
  assign ex_aluop         = ex_bundle_p1.aluop;
  assign ex_alu_b_src     = ex_bundle_p1.alu_b_src;
  assign ex_mem_wen_pick  = ex_bundle_p1.mem_wen_pick;
  assign ex_reg_write_src = ex_bundle_p1.reg_write_src;
  assign ex_a             = ex_bundle_p1.a;
  assign ex_b             = ex_bundle_p1.b;
  assign ex_imm           = ex_bundle_p1.imm;
  assign ex_pc            = ex_bundle_p1.pc;
  assign ex_dst           = ex_bundle_p1.dst;
  assign ex_fwd_a         = ex_bundle_p1.fwd_a;
  assign ex_fwd_b         = ex_bundle_p1.fwd_b;

endmodule

// File: tb/tb_id_ex_interlock.sv
module tb_id_ex_interlock;
  localparam int DW = 32;
  localparam logic [5:0] TGT_RD  = 6'b000001;
  localparam logic [5:0] TGT_HI  = 6'b000010;
  localparam logic [5:0] TGT_NOP = 6'b001000;
  localparam logic [5:0] TGT_RT  = 6'b010000;
  localparam logic [5:0] TGT_R31 = 6'b100000;

  logic clk = 1'b0;
  logic rst, id_valid, id_ready;
  logic [4:0] id_rs, id_rt, id_rd;
  logic id_reg_a_valid, id_reg_b_valid, id_mem_read, id_reg_write;
  logic [5:0] id_reg_write_tgt;
  logic [15:0] id_aluop, id_reg_write_src;
  logic [3:0] id_alu_b_src;
  logic [4:0] id_mem_wen_pick;
  logic [DW-1:0] id_a, id_b, id_imm, id_pc;
  logic ex_ready, ex_valid;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic ex_reg_a_valid, ex_reg_b_valid, ex_mem_read, ex_reg_write;
  logic [5:0] ex_reg_write_tgt;
  logic [15:0] ex_aluop, ex_reg_write_src;
  logic [3:0] ex_alu_b_src;
  logic [4:0] ex_mem_wen_pick;
  logic [DW-1:0] ex_a, ex_b, ex_imm, ex_pc;
  logic [4:0] ex_dst;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  id_ex_interlock #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_a_valid(id_reg_a_valid), .id_reg_b_valid(id_reg_b_valid),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .id_reg_write_tgt(id_reg_write_tgt), .id_aluop(id_aluop),
    .id_alu_b_src(id_alu_b_src), .id_mem_wen_pick(id_mem_wen_pick),
    .id_reg_write_src(id_reg_write_src),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_pc(id_pc),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_a_valid(ex_reg_a_valid), .ex_reg_b_valid(ex_reg_b_valid),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_reg_write_tgt(ex_reg_write_tgt), .ex_aluop(ex_aluop),
    .ex_alu_b_src(ex_alu_b_src), .ex_mem_wen_pick(ex_mem_wen_pick),
    .ex_reg_write_src(ex_reg_write_src),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_dst(ex_dst), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .stall_cycles(stall_cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a list of the instructions occupying EX, MEM, WB
  // (index 0 is the youngest), plus the expected EX register contents.
  typedef struct {
    bit vld;
    int dst;
    bit ld;
  } rec_t;
  rec_t hist[$];
  bit          m_valid;
  int          m_dst, m_fa, m_fb;
  logic [31:0] m_stalls;
  logic [DW-1:0] m_a;
  logic [15:0] m_aluop;
  logic [5:0]  m_tgt;

  // GPR written by the instruction on the ID inputs, 0 if none.
  function automatic int dst_of();
    int d;
    d = 0;
    if (id_reg_write) begin
      if (id_reg_write_tgt[0])      d = int'(id_rd);
      else if (id_reg_write_tgt[4]) d = int'(id_rt);
      else if (id_reg_write_tgt[5]) d = 31;
    end
    return d;
  endfunction

  // -1 = must stall, otherwise the forwarding select. The youngest matching
  // producer decides.
  function automatic int verdict(input bit rv, input logic [4:0] src);
    int r;
    bit found;
    r = 0;
    found = 0;
    if (rv && src != 5'd0) begin
      for (int i = 0; i < hist.size(); i++) begin
        if (!found && hist[i].vld && hist[i].dst == int'(src)) begin
          found = 1;
          if (i < 2 && hist[i].ld) r = -1;
          else if (i < 2)          r = i + 1;
          else                     r = 0;
        end
      end
    end
    return r;
  endfunction

  function automatic bit model_ready();
    return !rst && ex_ready && verdict(id_reg_a_valid, id_rs) >= 0
           && verdict(id_reg_b_valid, id_rt) >= 0;
  endfunction

  task automatic model_reset();
    rec_t e;
    e.vld = 0; e.dst = 0; e.ld = 0;
    hist = {};
    for (int i = 0; i < 3; i++) hist.push_back(e);
    m_valid = 0; m_dst = 0; m_fa = 0; m_fb = 0; m_stalls = 0;
    m_a = '0; m_aluop = '0; m_tgt = '0;
  endtask

  task automatic model_step();
    int va, vb;
    bit haz, issue;
    rec_t r;
    if (rst) begin
      model_reset();
    end else if (ex_ready) begin
      va = verdict(id_reg_a_valid, id_rs);
      vb = verdict(id_reg_b_valid, id_rt);
      haz = (va < 0) || (vb < 0);
      issue = id_valid && !haz;
      r.vld = issue && dst_of() != 0;
      r.dst = dst_of();
      r.ld  = id_mem_read;
      hist.push_front(r);
      void'(hist.pop_back());
      m_valid = issue;
      m_dst   = issue ? dst_of() : 0;
      m_fa    = issue ? va : 0;
      m_fb    = issue ? vb : 0;
      m_a     = issue ? id_a : '0;
      m_aluop = issue ? id_aluop : '0;
      m_tgt   = issue ? id_reg_write_tgt : '0;
      if (id_valid && haz) m_stalls = m_stalls + 32'd1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int rs, input int rt, input int rd,
                           input bit av, input bit bv, input bit mr,
                           input bit rw, input logic [5:0] tgt);
    id_valid         = 1'b1;
    id_rs            = 5'(rs);
    id_rt            = 5'(rt);
    id_rd            = 5'(rd);
    id_reg_a_valid   = av;
    id_reg_b_valid   = bv;
    id_mem_read      = mr;
    id_reg_write     = rw;
    id_reg_write_tgt = tgt;
    id_aluop         = 16'(1 << $urandom_range(0, 15));
    id_alu_b_src     = 4'(1 << $urandom_range(0, 3));
    id_mem_wen_pick  = 5'(1 << $urandom_range(0, 4));
    id_reg_write_src = 16'(1 << $urandom_range(0, 15));
    id_a             = $urandom;
    id_b             = $urandom;
    id_imm           = $urandom;
    id_pc            = $urandom;
  endtask

  task automatic lw(input int rt, input int base);
    set_instr(base, rt, 0, 1, 0, 1, 1, TGT_RT);
  endtask
  task automatic addu(input int rd, input int rs, input int rt);
    set_instr(rs, rt, rd, 1, 1, 0, 1, TGT_RD);
  endtask
  task automatic addiu(input int rt, input int rs);
    set_instr(rs, rt, 0, 1, 0, 0, 1, TGT_RT);
  endtask
  task automatic nop();
    set_instr(0, 0, 0, 0, 0, 0, 0, TGT_NOP);
  endtask
  task automatic idle(input int n);
    id_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_ready = 1'b1;
    addu(3, 1, 2);
    #1;
    n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_id_ready: got %b want 0", id_ready); end
    tick(); tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stalls: got %0d want 0", stall_cycles); end
    n_tests++; if (ex_fwd_a !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_a: got %0d want 0", ex_fwd_a); end
    n_tests++; if (ex_aluop !== 16'd0 || ex_dst !== 5'd0) begin n_fail++; $display("FAIL reset_bundle: aluop %h dst %0d want 0", ex_aluop, ex_dst); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    int low;
    bit done;
    s0 = stall_cycles;
    lw(2, 1);
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_lw_ready: got %b want 1", id_ready); end
    tick();
    n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 5'd2) begin n_fail++; $display("FAIL lu_lw_issue: valid %b dst %0d want 1/2", ex_valid, ex_dst); end
    addu(3, 2, 4);
    low = 0; done = 0;
    for (int k = 0; k < 6 && !done; k++) begin
      #1;
      if (id_ready === 1'b1) done = 1;
      else begin
        low++;
        tick();
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: ex_valid %b want 0", ex_valid); end
      end
    end
    n_tests++; if (low != 2 || !done) begin n_fail++; $display("FAIL lu_stall_len: got %0d want 2", low); end
    tick();
    n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 5'd3) begin n_fail++; $display("FAIL lu_issue: valid %b dst %0d want 1/3", ex_valid, ex_dst); end
    n_tests++; if (ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0) begin n_fail++; $display("FAIL lu_fwd: a %0d b %0d want 0/0", ex_fwd_a, ex_fwd_b); end
    n_tests++; if (stall_cycles !== s0 + 32'd2) begin n_fail++; $display("FAIL lu_stall_count: got %0d want %0d", stall_cycles, s0 + 32'd2); end
  endtask

  task automatic test_alu_fwd();
    addiu(5, 0);
    tick();
    addu(6, 5, 5);
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b want 1", id_ready); end
    tick();
    n_tests++; if (ex_fwd_a !== 2'd1 || ex_fwd_b !== 2'd1) begin n_fail++; $display("FAIL alu_fwd_ex: a %0d b %0d want 1/1", ex_fwd_a, ex_fwd_b); end
    addiu(5, 0); tick();
    nop();       tick();
    addu(6, 5, 5);
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL gap_ready: got %b want 1", id_ready); end
    tick();
    n_tests++; if (ex_fwd_a !== 2'd2 || ex_fwd_b !== 2'd2) begin n_fail++; $display("FAIL gap_fwd_mem: a %0d b %0d want 2/2", ex_fwd_a, ex_fwd_b); end
  endtask

  task automatic test_mask();
    lw(7, 1); tick();
    addiu(7, 0);
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL mask_addiu_ready: got %b want 1", id_ready); end
    tick();
    addu(8, 7, 0);
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL mask_ready: got %b want 1", id_ready); end
    tick();
    n_tests++; if (ex_fwd_a !== 2'd1 || ex_fwd_b !== 2'd0) begin n_fail++; $display("FAIL mask_fwd: a %0d b %0d want 1/0", ex_fwd_a, ex_fwd_b); end
    idle(3);
  endtask

  task automatic test_hold();
    logic [31:0] s0;
    logic [DW-1:0] a0;
    lw(9, 1); tick();
    a0 = ex_a;
    s0 = stall_cycles;
    addu(10, 9, 9);
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready: cyc %0d got %b want 0", k, id_ready); end
      tick();
      n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 5'd9 || ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL hold_ex: cyc %0d valid %b dst %0d ld %b want 1/9/1", k, ex_valid, ex_dst, ex_mem_read); end
      n_tests++; if (ex_a !== a0) begin n_fail++; $display("FAIL hold_a: cyc %0d got %h want %h", k, ex_a, a0); end
      n_tests++; if (stall_cycles !== s0) begin n_fail++; $display("FAIL hold_stalls: cyc %0d got %0d want %0d", k, stall_cycles, s0); end
    end
    ex_ready = 1'b1;
    idle(3);
  endtask

  task automatic test_zero_dst();
    lw(0, 1); tick();
    n_tests++; if (ex_dst !== 5'd0) begin n_fail++; $display("FAIL zero_dst: got %0d want 0", ex_dst); end
    addu(10, 0, 0);
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", id_ready); end
    tick();
    n_tests++; if (ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0) begin n_fail++; $display("FAIL zero_fwd: a %0d b %0d want 0/0", ex_fwd_a, ex_fwd_b); end
    // load-flagged write to hi with rd=11: no GPR write
    set_instr(1, 2, 11, 1, 0, 1, 1, TGT_HI); tick();
    n_tests++; if (ex_dst !== 5'd0) begin n_fail++; $display("FAIL hi_dst: got %0d want 0", ex_dst); end
    addu(12, 11, 11);
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL hi_ready: got %b want 1", id_ready); end
    tick();
    n_tests++; if (ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0) begin n_fail++; $display("FAIL hi_fwd: a %0d b %0d want 0/0", ex_fwd_a, ex_fwd_b); end
    // load with reg_write=0 must not stall its reader
    set_instr(1, 13, 0, 1, 0, 1, 0, TGT_RT); tick();
    addu(14, 13, 13);
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL nowr_ready: got %b want 1", id_ready); end
    tick();
    // jal-style write to r31
    set_instr(0, 0, 0, 0, 0, 0, 1, TGT_R31); tick();
    n_tests++; if (ex_dst !== 5'd31) begin n_fail++; $display("FAIL r31_dst: got %0d want 31", ex_dst); end
    addu(15, 31, 0); tick();
    n_tests++; if (ex_fwd_a !== 2'd1) begin n_fail++; $display("FAIL r31_fwd: got %0d want 1", ex_fwd_a); end
    idle(3);
  endtask

  task automatic test_rst_mid_stall();
    lw(12, 1); tick();
    addu(13, 12, 12);
    #1;
    n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL rms_stall: got %b want 0", id_ready); end
    rst = 1'b1;
    tick();
    n_tests++; if (ex_valid !== 1'b0 || stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rms_reset: valid %b stalls %0d want 0/0", ex_valid, stall_cycles); end
    rst = 1'b0;
    #1;
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL rms_ready: got %b want 1", id_ready); end
    tick();
    n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 5'd13 || ex_fwd_a !== 2'd0) begin n_fail++; $display("FAIL rms_issue: valid %b dst %0d fwd %0d want 1/13/0", ex_valid, ex_dst, ex_fwd_a); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0,
                6'(1 << $urandom_range(0, 5)));
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      rst      = ($urandom_range(0, 63) == 0);
      #1;
      n_tests++; if (id_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready: cyc %0d got %b want %b", i, id_ready, model_ready()); end
      tick();
      n_tests++; if (ex_valid !== m_valid || ex_dst !== 5'(m_dst)) begin n_fail++; $display("FAIL rnd_issue: cyc %0d valid %b dst %0d want %b/%0d", i, ex_valid, ex_dst, m_valid, m_dst); end
      n_tests++; if (ex_fwd_a !== 2'(m_fa) || ex_fwd_b !== 2'(m_fb)) begin n_fail++; $display("FAIL rnd_fwd: cyc %0d a %0d b %0d want %0d/%0d", i, ex_fwd_a, ex_fwd_b, m_fa, m_fb); end
      n_tests++; if (stall_cycles !== m_stalls) begin n_fail++; $display("FAIL rnd_stalls: cyc %0d got %0d want %0d", i, stall_cycles, m_stalls); end
      n_tests++; if (ex_a !== m_a || ex_aluop !== m_aluop || ex_reg_write_tgt !== m_tgt) begin n_fail++; $display("FAIL rnd_bundle: cyc %0d a %h op %h tgt %b want %h/%h/%b", i, ex_a, ex_aluop, ex_reg_write_tgt, m_a, m_aluop, m_tgt); end
    end
    rst = 1'b0;
    ex_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    ex_ready = 1'b1;
    nop();
    id_valid = 1'b0;
    model_reset();
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_mask();
    test_hold();
    test_zero_dst();
    test_rst_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
